// File: rtl/matrix_result_tx.sv
// Purpose: serialises a result matrix (rows, cols header then row-major data) over an 8N1 UART line.
// Latency: start bit begins the cycle after start is sampled; done pulses the cycle after the last stop bit.
// Backpressure: none downstream; start is ignored while busy and accepted again from the done cycle on.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   start           - transfer request, sampled in IDLE or in the done cycle
//   rows, cols      - matrix dimensions, clamped to MAX_M / MAX_P at capture
//   result          - 32-bit matrix [MAX_M][MAX_P], snapshotted at capture
//   uart_tx         - serial line, idle high
//   busy, done      - transfer in progress / one-cycle end-of-transfer pulse
//
// Optional feature: define MATRIX_TX_CHECKSUM_EN to append an XOR checksum byte.
module matrix_result_tx #(
    parameter int MAX_M        = 4,
    parameter int MAX_P        = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] rows,
    input  logic [31:0] cols,
    input  logic [31:0] result [MAX_M][MAX_P],
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int RW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
    localparam int CW = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT_BYTE, FINISH
    } state_t;

    typedef enum logic [1:0] {
        PH_ROWS, PH_COLS, PH_DATA, PH_CSUM
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q;
    logic [TW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [1:0]      bw_q;        // byte within current word, 0 = MSB
    logic [RW-1:0]   i_q;
    logic [CW-1:0]   j_q;

    logic [31:0]     rows_q, cols_q;
    logic [31:0]     snap [MAX_M][MAX_P];

    logic [31:0]     word;
    logic [7:0]      cur_byte;
    logic            accept, bit_end, stop_end;
    logic            hdr_empty, last_elem, last_byte;

`ifdef MATRIX_TX_CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    assign accept    = ((state_q == IDLE) || (state_q == FINISH)) && start;
    assign bit_end   = (cnt_q == BIT_LAST);
    assign stop_end  = (cnt_q == STOP_LAST);
    assign hdr_empty = (rows_q == 32'd0) || (cols_q == 32'd0);
    assign last_elem = (32'(i_q) == rows_q - 32'd1) && (32'(j_q) == cols_q - 32'd1);

`ifdef MATRIX_TX_CHECKSUM_EN
    assign last_byte = (phase_q == PH_CSUM);
`else
    assign last_byte = (bw_q == 2'd3) &&
                       (((phase_q == PH_COLS) && hdr_empty) ||
                        ((phase_q == PH_DATA) && last_elem));
`endif

    // Snapshot of the request; only meaningful once a transfer is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            rows_q <= (rows > 32'(MAX_M)) ? 32'(MAX_M) : rows;
            cols_q <= (cols > 32'(MAX_P)) ? 32'(MAX_P) : cols;
            snap   <= result;
        end
    end

    // Byte currently on the line, selected from the snapshot.
    always_comb begin
        word = 32'd0;
        case (phase_q)
            PH_ROWS: word = rows_q;
            PH_COLS: word = cols_q;
            PH_DATA: word = snap[i_q][j_q];
            default: word = 32'd0;
        endcase
        case (bw_q)
            2'd0:    cur_byte = word[31:24];
            2'd1:    cur_byte = word[23:16];
            2'd2:    cur_byte = word[15:8];
            default: cur_byte = word[7:0];
        endcase
`ifdef MATRIX_TX_CHECKSUM_EN
        if (phase_q == PH_CSUM) cur_byte = csum_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // LOAD is the first cycle of the start bit and NEXT_BYTE the last cycle of
    // the stop bit, so neither adds line time between frames.
    always_comb begin
        state_d = state_q;
        uart_tx = 1'b1;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                uart_tx = 1'b0;
                state_d = START_BIT;
            end
            START_BIT: begin
                uart_tx = 1'b0;
                if (bit_end) state_d = DATA_BITS;
            end
            DATA_BITS: begin
                uart_tx = cur_byte[bit_q];
                if (bit_end && (bit_q == 3'd7)) state_d = STOP_BIT;
            end
            STOP_BIT: begin
                if (stop_end) state_d = NEXT_BYTE;
            end
            NEXT_BYTE: begin
                state_d = last_byte ? FINISH : START_BIT;
            end
            FINISH: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = start ? LOAD : IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            bw_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            phase_q <= PH_ROWS;
`ifdef MATRIX_TX_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    if (start) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        bw_q    <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        phase_q <= PH_ROWS;
`ifdef MATRIX_TX_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                LOAD: cnt_q <= TW'(1);  // LOAD already spent one start-bit cycle
                START_BIT: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        bit_q <= bit_q + 3'd1;
`ifdef MATRIX_TX_CHECKSUM_EN
                        if (bit_q == 3'd7) csum_q <= csum_q ^ cur_byte;
`endif
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                STOP_BIT: begin
                    if (stop_end) cnt_q <= '0;
                    else          cnt_q <= cnt_q + TW'(1);
                end
                NEXT_BYTE: begin
                    if (!last_byte) begin
                        if (bw_q != 2'd3) begin
                            bw_q <= bw_q + 2'd1;
                        end else begin
                            bw_q <= 2'd0;
                            case (phase_q)
                                PH_ROWS: phase_q <= PH_COLS;
                                PH_COLS: phase_q <= hdr_empty ? PH_CSUM : PH_DATA;
                                PH_DATA: begin
                                    if (32'(j_q) == cols_q - 32'd1) begin
                                        j_q <= '0;
                                        if (32'(i_q) == rows_q - 32'd1) phase_q <= PH_CSUM;
                                        else                            i_q     <= i_q + RW'(1);
                                    end else begin
                                        j_q <= j_q + CW'(1);
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_tx.sv
module tb_matrix_result_tx;

    localparam int CPB   = 4;
    localparam int MM    = 4;
    localparam int MP    = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rows_i = 32'd0;
    logic [31:0] cols_i = 32'd0;
    logic [31:0] mat [MM][MP];
    logic        uart_tx, busy, done;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         line_q [$];

    always #5 clk = ~clk;

    matrix_result_tx #(.MAX_M(MM), .MAX_P(MP), .CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rows    (rows_i),
        .cols    (cols_i),
        .result  (mat),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic fill_random();
        for (int i = 0; i < MM; i++)
            for (int j = 0; j < MP; j++)
                mat[i][j] = $urandom;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    // Reference byte stream: clamped header, row-major words, optional XOR.
    task automatic build_expected(input logic [31:0] r, input logic [31:0] c);
        logic [31:0] rc, cc;
        logic [7:0]  x;
        exp_q.delete();
        rc = (r > MM) ? MM : r;
        cc = (c > MP) ? MP : c;
        push_word(rc);
        push_word(cc);
        for (int i = 0; i < int'(rc); i++)
            for (int j = 0; j < int'(cc); j++)
                push_word(mat[i][j]);
        x = 8'h00;
        foreach (exp_q[k]) x = x ^ exp_q[k];
`ifdef MATRIX_TX_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Runs one transfer, records the line every cycle and checks it.
    task automatic run_xfer(input string name, input logic [31:0] r, input logic [31:0] c,
                            input int perturb, output int done_at);
        int limit, busy_low, wave_bad, first_bad, byte_bad, bad_idx;
        bit exp_bit;
        logic [7:0] b;
        build_expected(r, c);
        rows_i = r;
        cols_i = c;
        @(negedge clk);
        start = 1'b1;
        line_q.delete();
        got_q.delete();
        done_at  = -1;
        busy_low = 0;
        limit    = exp_q.size() * FRAME + 20;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_at = cyc;
                break;
            end
            line_q.push_back(uart_tx);
            if (!busy) busy_low++;
            if (cyc == 1) start = 1'b0;
            if (perturb > 0 && cyc == perturb) begin
                start = 1'b1;
                fill_random();
                rows_i = $urandom_range(1, 4);
            end
            if (perturb > 0 && cyc == perturb + 1) start = 1'b0;
        end
        start = 1'b0;

        checks++;
        if (done_at - 1 !== exp_queue_cycles()) $display("FAIL %s done_latency got %0d want %0d", name, done_at - 1, exp_queue_cycles());
        else passes++;

        checks++;
        if ({busy, uart_tx} !== 2'b01) $display("FAIL %s done_cycle busy/tx got %b want 01", name, {busy, uart_tx});
        else passes++;

        checks++;
        if (busy_low !== 0) $display("FAIL %s busy_low_cycles got %0d want 0", name, busy_low);
        else passes++;

        wave_bad = 0;
        first_bad = -1;
        for (int x = 0; x < exp_queue_cycles(); x++) begin
            int n, k;
            n = x / FRAME;
            k = (x % FRAME) / CPB;
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp_q[n][k-1];
            if (x >= line_q.size() || line_q[x] !== exp_bit) begin
                wave_bad++;
                if (first_bad < 0) first_bad = x;
            end
        end
        checks++;
        if (wave_bad !== 0 || line_q.size() !== exp_queue_cycles())
            $display("FAIL %s waveform bad_cycles=%0d first=%0d len got %0d want %0d", name, wave_bad, first_bad, line_q.size(), exp_queue_cycles());
        else passes++;

        for (int n = 0; n < line_q.size() / FRAME; n++) begin
            for (int k = 0; k < 8; k++) b[k] = line_q[n*FRAME + (k+1)*CPB + CPB/2];
            got_q.push_back(b);
        end
        byte_bad = 0;
        bad_idx = -1;
        foreach (exp_q[n]) begin
            if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
                byte_bad++;
                if (bad_idx < 0) bad_idx = n;
            end
        end
        checks++;
        if (byte_bad !== 0 || got_q.size() !== exp_q.size())
            $display("FAIL %s bytes bad=%0d first_idx=%0d count got %0d want %0d", name, byte_bad, bad_idx, got_q.size(), exp_q.size());
        else passes++;

        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) $display("FAIL %s after_done done/busy got %b want 00", name, {done, busy});
        else passes++;
    endtask

    function automatic int exp_queue_cycles();
        return exp_q.size() * FRAME;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) $display("FAIL reset_uart_tx got %b want 1", uart_tx); else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({uart_tx, busy, done} !== 3'b100) $display("FAIL idle_after_reset got %b want 100", {uart_tx, busy, done}); else passes++;
    endtask

    task automatic test_single_word();
        int d;
        int want;
        fill_random();
        mat[0][0] = 32'hA1B2C3D4;
`ifdef MATRIX_TX_CHECKSUM_EN
        want = 520;
`else
        want = 480;
`endif
        run_xfer("single", 32'd1, 32'd1, 0, d);
        checks++;
        if (d - 1 !== want) $display("FAIL single_done_cycle got %0d want %0d", d - 1, want); else passes++;
        checks++;
        if (got_q.size() < 12 || {got_q[8], got_q[9], got_q[10], got_q[11]} !== 32'hA1B2C3D4)
            $display("FAIL single_data_bytes got size %0d want A1B2C3D4", got_q.size());
        else passes++;
`ifdef MATRIX_TX_CHECKSUM_EN
        checks++;
        if (got_q.size() < 13 || got_q[12] !== 8'h04) $display("FAIL single_checksum got size %0d want 04", got_q.size()); else passes++;
`endif
    endtask

    task automatic test_row_major();
        int d;
        for (int i = 0; i < MM; i++)
            for (int j = 0; j < MP; j++)
                mat[i][j] = 32'h10 * i + j;
        run_xfer("row_major", 32'd2, 32'd3, 0, d);
        checks++;
        if (got_q.size() < 32 || got_q[23] !== 8'h10 || got_q[31] !== 8'h12)
            $display("FAIL row_major_order got size %0d want word3=0x10 word5=0x12", got_q.size());
        else passes++;
    endtask

    task automatic test_clamp_empty();
        int d;
        fill_random();
        run_xfer("clamp", 32'd6, 32'd4, 0, d);
        checks++;
        if (got_q.size() < 8 || got_q[3] !== 8'd4 || got_q[7] !== 8'd4)
            $display("FAIL clamp_header got size %0d want rows=4 cols=4", got_q.size());
        else passes++;
        run_xfer("empty", 32'd0, 32'd3, 0, d);
        checks++;
`ifdef MATRIX_TX_CHECKSUM_EN
        if (got_q.size() !== 9) $display("FAIL empty_len got %0d want 9", got_q.size()); else passes++;
`else
        if (got_q.size() !== 8) $display("FAIL empty_len got %0d want 8", got_q.size()); else passes++;
`endif
    endtask

    task automatic test_busy_snapshot();
        int d, extra;
        fill_random();
        run_xfer("snapshot", 32'd2, 32'd2, 50, d);
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || done || !uart_tx) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL no_second_xfer active_cycles got %0d want 0", extra); else passes++;
    endtask

    task automatic test_reset_abort();
        int d, activity;
        fill_random();
        rows_i = 32'd1;
        cols_i = 32'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (98) @(negedge clk);
        checks++;
        if ({busy, uart_tx} !== 2'b10) $display("FAIL abort_pre busy/tx got %b want 10", {busy, uart_tx}); else passes++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({uart_tx, busy, done} !== 3'b100) $display("FAIL abort_immediate tx/busy/done got %b want 100", {uart_tx, busy, done}); else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy || done || !uart_tx) activity++;
        end
        checks++;
        if (activity !== 0) $display("FAIL abort_quiet active_cycles got %0d want 0", activity); else passes++;
        run_xfer("after_abort", 32'd2, 32'd1, 0, d);
    endtask

    task automatic test_random();
        int d;
        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_xfer($sformatf("random%0d", t), $urandom_range(0, 6), $urandom_range(0, 6), 0, d);
        end
    endtask

    initial begin
        for (int i = 0; i < MM; i++)
            for (int j = 0; j < MP; j++)
                mat[i][j] = 32'd0;
        test_reset();
        test_single_word();
        test_row_major();
        test_clamp_empty();
        test_busy_snapshot();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
